cntdown_ctrl: RTL and testbench

CNTDOWN_CTRL -- requirements
Module: cntdown_ctrl

---
 rtl/cntdown_ctrl.sv | 158 +++++++++++++++
 tb/tb_cntdown_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cntdown_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cntdown_ctrl
//  Purpose  : Two-digit BCD countdown timer controller. A prescaler divides
//             clk into one-second ticks. Each tick decrements the BCD value.
//             Reaching 00 raises the alarm.
//  Ports    : clk          - system clock (rising edge)
//             n_rst        - synchronous active-low reset
//             start        - load presets and (re)start counting
//             pause        - toggle RUN <-> PAUSE
//             clear        - abort to IDLE
//             load_tens/_ones - BCD presets (values above 9 clamp to 9)
//             one_sec_flag - one-cycle tick pulse while running
//             tens_out/ones_out - current BCD value
//             running      - high in RUN
//             alarm        - high in DONE
//             done_pulse   - single-cycle pulse on entry to DONE
//  Revision : 1.0 - initial release
// ============================================================================
module cntdown_ctrl #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic       one_sec_flag,
    output logic [3:0] tens_out,
    output logic [3:0] ones_out,
    output logic       running,
    output logic       alarm,
    output logic       done_pulse
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    tens_q, tens_d;
    logic [3:0]    ones_q, ones_d;
    logic          flag_q, running_q, alarm_q, done_pulse_q;

    logic [3:0] ld_tens_w, ld_ones_w;
    logic       ld_zero_w;
    logic       tick_w;
    logic       last_sec_w;

    assign ld_tens_w  = (load_tens > 4'd9) ? 4'd9 : load_tens;
    assign ld_ones_w  = (load_ones > 4'd9) ? 4'd9 : load_ones;
    assign ld_zero_w  = (ld_tens_w == 4'd0) && (ld_ones_w == 4'd0);
    assign tick_w     = (state_q == RUN) && (presc_q == PRESC_LAST);
    // The only value whose decrement lands on 00.
    assign last_sec_w = (tens_q == 4'd0) && (ones_q == 4'd1);

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tens_d  = tens_q;
        ones_d  = ones_q;

        if (clear) begin
            // Loading here makes the first IDLE cycle already show the presets.
            state_d = IDLE;
            presc_d = '0;
            tens_d  = ld_tens_w;
            ones_d  = ld_ones_w;
        end else if (start) begin
            // Overrides any coincident tick: no decrement on this edge.
            presc_d = '0;
            tens_d  = ld_tens_w;
            ones_d  = ld_ones_w;
            state_d = ld_zero_w ? DONE : RUN;
        end else begin
            case (state_q)
                IDLE: begin
                    tens_d = ld_tens_w;
                    ones_d = ld_ones_w;
                end
                RUN: begin
                    // The cycle in which pause is requested still counts.
                    if (tick_w) begin
                        presc_d = '0;
                        if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                        end else begin
                            ones_d = 4'd9;
                            tens_d = tens_q - 4'd1;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                    if (tick_w && last_sec_w) begin
                        state_d = DONE;
                    end else if (pause) begin
                        state_d = PAUSE;
                    end
                end
                PAUSE: begin
                    if (pause) begin
                        state_d = RUN;
                    end
                end
                DONE: begin
                    presc_d = '0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            tens_q       <= 4'd0;
            ones_q       <= 4'd0;
            flag_q       <= 1'b0;
            running_q    <= 1'b0;
            alarm_q      <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            tens_q       <= tens_d;
            ones_q       <= ones_d;
            // Status outputs are computed from next state so they line up
            // with the state register.
            flag_q       <= (state_d == RUN) && (presc_d == PRESC_LAST);
            running_q    <= (state_d == RUN);
            alarm_q      <= (state_d == DONE);
            done_pulse_q <= (state_d == DONE) && (state_q != DONE);
        end
    end

    assign one_sec_flag = flag_q;
    assign tens_out     = tens_q;
    assign ones_out     = ones_q;
    assign running      = running_q;
    assign alarm        = alarm_q;
    assign done_pulse   = done_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_cntdown_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cntdown_ctrl
//  Purpose  : Directed self-checking bench for cntdown_ctrl with TICK_DIV=4.
//             Outputs are packed as {flag, running, alarm, done_pulse,
//             tens, ones} and compared one cycle at a time, 1 time unit
//             after each rising edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cntdown_ctrl;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       n_rst, start, pause, clear;
    logic [3:0] load_tens, load_ones;
    logic       one_sec_flag, running, alarm, done_pulse;
    logic [3:0] tens_out, ones_out;
    logic [11:0] obs;
    logic [11:0] exp_v;
    int total = 0;
    int bad   = 0;

    cntdown_ctrl #(.TICK_DIV(TICK_DIV)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .pause        (pause),
        .clear        (clear),
        .load_tens    (load_tens),
        .load_ones    (load_ones),
        .one_sec_flag (one_sec_flag),
        .tens_out     (tens_out),
        .ones_out     (ones_out),
        .running      (running),
        .alarm        (alarm),
        .done_pulse   (done_pulse)
    );

    always #5 clk = ~clk;

    assign obs = {one_sec_flag, running, alarm, done_pulse, tens_out, ones_out};

    function automatic logic [11:0] mk(input logic f, input logic r, input logic a,
                                        input logic d, input logic [3:0] t,
                                        input logic [3:0] o);
        return {f, r, a, d, t, o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic do_start(input logic [3:0] t, input logic [3:0] o);
        load_tens = t; load_ones = o;
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0; load_tens = 4'd3; load_ones = 4'd4;
        step(); step();
        exp_v = mk(0, 0, 0, 0, 4'd0, 4'd0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset got=%h exp=%h", obs, exp_v); end
        n_rst = 1'b1; step();
        exp_v = mk(0, 0, 0, 0, 4'd3, 4'd4);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL reset_release got=%h exp=%h", obs, exp_v); end
        pause = 1'b1; step(); pause = 1'b0;
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL idle_pause got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_countdown();
        do_start(4'd1, 4'd2);
        for (int n = 12; n >= 1; n--) begin
            for (int c = 0; c < TICK_DIV; c++) begin
                exp_v = mk(c == TICK_DIV - 1, 1, 0, 0, 4'(n / 10), 4'(n % 10));
                total++;
                if (obs !== exp_v) begin
                    bad++; $display("FAIL countdown n=%0d c=%0d got=%h exp=%h", n, c, obs, exp_v);
                end
                step();
            end
        end
        exp_v = mk(0, 0, 1, 1, 4'd0, 4'd0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL done_entry got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = mk(0, 0, 1, 0, 4'd0, 4'd0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL done_hold got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_pause();
        do_clear();
        do_start(4'd0, 4'd3);
        for (int c = 0; c < TICK_DIV; c++) begin
            exp_v = mk(c == TICK_DIV - 1, 1, 0, 0, 4'd0, 4'd3);
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL pause_pre c=%0d got=%h exp=%h", c, obs, exp_v); end
            step();
        end
        // Now at 02 with prescaler 0; the pause edge still counts this cycle.
        pause = 1'b1; step(); pause = 1'b0;
        for (int i = 0; i < 10; i++) begin
            exp_v = mk(0, 0, 0, 0, 4'd0, 4'd2);
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL paused i=%0d got=%h exp=%h", i, obs, exp_v); end
            step();
        end
        pause = 1'b1; step(); pause = 1'b0;
        // Prescaler resumes at 1: flag two cycles later.
        for (int c = 1; c < TICK_DIV; c++) begin
            exp_v = mk(c == TICK_DIV - 1, 1, 0, 0, 4'd0, 4'd2);
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL resume c=%0d got=%h exp=%h", c, obs, exp_v); end
            step();
        end
        exp_v = mk(0, 1, 0, 0, 4'd0, 4'd1);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL resume_dec got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_zero_start();
        do_clear();
        do_start(4'd0, 4'd0);
        exp_v = mk(0, 0, 1, 1, 4'd0, 4'd0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL zero_start got=%h exp=%h", obs, exp_v); end
        for (int i = 0; i < 5; i++) begin
            step();
            exp_v = mk(0, 0, 1, 0, 4'd0, 4'd0);
            total++;
            if (obs !== exp_v) begin bad++; $display("FAIL zero_hold i=%0d got=%h exp=%h", i, obs, exp_v); end
        end
    endtask

    task automatic test_clamp();
        do_clear();
        load_tens = 4'hF; load_ones = 4'hC; step();
        exp_v = mk(0, 0, 0, 0, 4'd9, 4'd9);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL clamp_idle got=%h exp=%h", obs, exp_v); end
        do_start(4'hF, 4'hC);
        exp_v = mk(0, 1, 0, 0, 4'd9, 4'd9);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL clamp_run got=%h exp=%h", obs, exp_v); end
        step(); step(); step();
        exp_v = mk(1, 1, 0, 0, 4'd9, 4'd9);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL clamp_flag got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = mk(0, 1, 0, 0, 4'd9, 4'd8);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL clamp_dec got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_clear_on_tick();
        do_clear();
        do_start(4'd0, 4'd5);
        step(); step(); step();
        exp_v = mk(1, 1, 0, 0, 4'd0, 4'd5);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL clr_flag got=%h exp=%h", obs, exp_v); end
        load_tens = 4'd0; load_ones = 4'd7;
        clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
        exp_v = mk(0, 0, 0, 0, 4'd0, 4'd7);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL clr_over_tick got=%h exp=%h", obs, exp_v); end
        step();
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL clr_idle got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_back_to_back();
        do_clear();
        do_start(4'd0, 4'd5);
        step(); step(); step();
        exp_v = mk(1, 1, 0, 0, 4'd0, 4'd5);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL b2b_flag got=%h exp=%h", obs, exp_v); end
        do_start(4'd0, 4'd4);
        exp_v = mk(0, 1, 0, 0, 4'd0, 4'd4);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL b2b_restart got=%h exp=%h", obs, exp_v); end
        step(); step();
        exp_v = mk(0, 1, 0, 0, 4'd0, 4'd4);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL b2b_noflag got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = mk(1, 1, 0, 0, 4'd0, 4'd4);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL b2b_flag2 got=%h exp=%h", obs, exp_v); end
        step();
        exp_v = mk(0, 1, 0, 0, 4'd0, 4'd3);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL b2b_dec got=%h exp=%h", obs, exp_v); end
    endtask

    task automatic test_reset_mid();
        // Still running from the previous scenario.
        load_tens = 4'd1; load_ones = 4'd2;
        n_rst = 1'b0; step();
        exp_v = mk(0, 0, 0, 0, 4'd0, 4'd0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rst_mid got=%h exp=%h", obs, exp_v); end
        n_rst = 1'b1; step();
        exp_v = mk(0, 0, 0, 0, 4'd1, 4'd2);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rst_mid_idle got=%h exp=%h", obs, exp_v); end
        do_start(4'd0, 4'd0);
        do_start(4'd0, 4'd2);
        exp_v = mk(0, 1, 0, 0, 4'd0, 4'd2);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL done_restart got=%h exp=%h", obs, exp_v); end
        do_start(4'd0, 4'd0);
        n_rst = 1'b0; start = 1'b1; step(); start = 1'b0; n_rst = 1'b1;
        exp_v = mk(0, 0, 0, 0, 4'd0, 4'd0);
        total++;
        if (obs !== exp_v) begin bad++; $display("FAIL rst_done got=%h exp=%h", obs, exp_v); end
    endtask

    initial begin
        n_rst = 1'b0; start = 1'b0; pause = 1'b0; clear = 1'b0;
        load_tens = 4'd0; load_ones = 4'd0;
        test_reset();
        test_countdown();
        test_pause();
        test_zero_start();
        test_clamp();
        test_clear_on_tick();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
